// File: rtl/if_id_pipe_buffer_if.sv
// Fetch-to-decode handshake bundle. The buffer takes the slave side; the
// fetch/decode environment drives the master side.
interface if_id_pipe_buffer_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_pc_4;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_4;
    logic [XLEN-1:0] out_instr;

    modport master (
        output in_valid, in_pc, in_pc_4, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_pc_4, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_pc_4, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_pc_4, out_instr
    );
endinterface

// File: rtl/if_id_pipe_buffer.sv
// IF/ID stage as a DEPTH-entry in-order FIFO with valid/ready on both sides,
// redirect flush, NOP bubble when empty, and a saturating decode-stall counter.
module if_id_pipe_buffer #(
    parameter int              XLEN  = 32,
    parameter int              DEPTH = 2,
    parameter logic [XLEN-1:0] NOP   = 32'h00000013,
    parameter int              CNT_W = 16,
    localparam int             PW    = $clog2(DEPTH),
    localparam int             CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    if_id_pipe_buffer_if.slave   bus,
    output logic [CW-1:0]        count,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] pc_4_mem  [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic            push, pop;

    // Handshake status comes only from the registered count: no in-to-out path.
    assign bus.in_ready  = (count != FULL);
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr]    <= bus.in_pc;
            pc_4_mem[wptr]  <= bus.in_pc_4;
            instr_mem[wptr] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (bus.out_valid && !bus.out_ready && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    always_comb begin
        bus.out_pc    = '0;
        bus.out_pc_4  = '0;
        bus.out_instr = NOP;
        if (bus.out_valid) begin
            bus.out_pc    = pc_mem[rptr];
            bus.out_pc_4  = pc_4_mem[rptr];
            bus.out_instr = instr_mem[rptr];
        end
    end
endmodule

// File: tb/tb_if_id_pipe_buffer.sv
// Scoreboard bench for if_id_pipe_buffer: a negedge monitor tracks a queue model
// of the buffer, while scenario tasks drive stimulus and make targeted checks.
module tb_if_id_pipe_buffer;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush, flush2;
    logic [1:0]  count, count2;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt2;

    int          tests = 0;
    int          fails = 0;
    ent_t        q[$];
    logic [15:0] stall_exp;

    if_id_pipe_buffer_if #(.XLEN(XLEN)) b ();
    if_id_pipe_buffer_if #(.XLEN(XLEN)) b2 ();

    if_id_pipe_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(b.slave),
        .count(count), .stall_cnt(stall_cnt));

    if_id_pipe_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .flush(flush2), .bus(b2.slave),
        .count(count2), .stall_cnt(stall_cnt2));

    always #5 clk = ~clk;

    // Scoreboard: compare the settled state, then apply what the coming edge does.
    always @(negedge clk) begin
        int   n;
        ent_t head;
        if (reset) begin
            q.delete();
            stall_exp = '0;
        end else begin
            n = q.size();
            head = (n != 0) ? q[0] : '{pc: 32'h0, pc_4: 32'h0, instr: NOP};
            tests++;
            if ({b.out_valid, b.in_ready, count} !== {(n != 0), (n < DEPTH), 2'(n)}) begin
                fails++;
                $display("FAIL sb_status: got valid=%b ready=%b count=%0d, expected valid=%b ready=%b count=%0d",
                         b.out_valid, b.in_ready, count, (n != 0), (n < DEPTH), n);
            end
            tests++;
            if (stall_cnt !== stall_exp) begin
                fails++;
                $display("FAIL sb_stall: got %0d expected %0d", stall_cnt, stall_exp);
            end
            tests++;
            if ({b.out_pc, b.out_pc_4, b.out_instr} !== head) begin
                fails++;
                $display("FAIL sb_head: got pc=%h pc4=%h instr=%h expected pc=%h pc4=%h instr=%h",
                         b.out_pc, b.out_pc_4, b.out_instr, head.pc, head.pc_4, head.instr);
            end
            if (n != 0 && !b.out_ready && !flush && stall_exp != 16'hFFFF) stall_exp++;
            if (flush) q.delete();
            else begin
                if (n != 0 && b.out_ready) void'(q.pop_front());
                if (b.in_valid && n < DEPTH) q.push_back({b.in_pc, b.in_pc_4, b.in_instr});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        b.in_valid = v;
        b.in_pc    = pc;
        b.in_pc_4  = pc + 32'd4;
        b.in_instr = instr;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        tests++;
        if ({b.out_valid, b.in_ready, count, stall_cnt} !== {1'b0, 1'b1, 2'd0, 16'd0}) begin
            fails++;
            $display("FAIL reset_status: got valid=%b ready=%b count=%0d stall=%0d", b.out_valid, b.in_ready, count, stall_cnt);
        end
        tests++;
        if ({b.out_pc, b.out_pc_4, b.out_instr} !== {32'h0, 32'h0, NOP}) begin
            fails++;
            $display("FAIL reset_outputs: got pc=%h pc4=%h instr=%h", b.out_pc, b.out_pc_4, b.out_instr);
        end
    endtask

    task automatic test_single;
        b.out_ready = 1'b1;
        drive(1'b1, 32'h100, 32'h00500093);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tests++;
        if ({b.out_valid, b.out_pc, b.out_pc_4, b.out_instr} !== {1'b1, 32'h100, 32'h104, 32'h00500093}) begin
            fails++;
            $display("FAIL single_out: got valid=%b pc=%h pc4=%h instr=%h", b.out_valid, b.out_pc, b.out_pc_4, b.out_instr);
        end
        tick();
        tests++;
        if ({b.out_valid, b.out_instr, count} !== {1'b0, NOP, 2'd0}) begin
            fails++;
            $display("FAIL single_bubble: got valid=%b instr=%h count=%0d", b.out_valid, b.out_instr, count);
        end
    endtask

    task automatic test_full;
        logic [15:0] s0;
        s0 = stall_exp;
        b.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        tests++;
        if ({count, b.in_ready} !== {2'd2, 1'b0}) begin
            fails++;
            $display("FAIL full_status: got count=%0d ready=%b expected count=2 ready=0", count, b.in_ready);
        end
        tests++;
        if (stall_cnt !== s0 + 16'd2) begin
            fails++;
            $display("FAIL full_stall: got %0d expected %0d", stall_cnt, s0 + 16'd2);
        end
        b.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (b.out_pc !== 32'h100 + 32'(4 * i)) begin
                fails++;
                $display("FAIL full_order: got pc=%h expected %h", b.out_pc, 32'h100 + 32'(4 * i));
            end
            tick();
        end
        tests++;
        if (b.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_drain: got valid=%b expected 0 (third entry must be dropped)", b.out_valid);
        end
    endtask

    task automatic test_flush;
        b.out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h2000);
        tick();
        drive(1'b1, 32'h304, 32'h2001);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h200, 32'h2002);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tests++;
        if ({count, b.out_valid, b.out_instr, b.out_pc} !== {2'd0, 1'b0, NOP, 32'h0}) begin
            fails++;
            $display("FAIL flush_clear: got count=%0d valid=%b instr=%h pc=%h", count, b.out_valid, b.out_instr, b.out_pc);
        end
        tests++;
        if (stall_cnt !== stall_exp || stall_exp == 16'd0) begin
            fails++;
            $display("FAIL flush_stall_kept: got %0d expected %0d (nonzero)", stall_cnt, stall_exp);
        end
        b.out_ready = 1'b1;
        tick(2);
    endtask

    task automatic test_back_to_back;
        b.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(4 * i), 32'h3000 + 32'(i));
            tick();
            tests++;
            if ({count, b.out_pc, b.out_instr} !== {2'd1, 32'(4 * i), 32'h3000 + 32'(i)}) begin
                fails++;
                $display("FAIL b2b_step%0d: got count=%0d pc=%h instr=%h expected count=1 pc=%h",
                         i, count, b.out_pc, b.out_instr, 32'(4 * i));
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tests++;
        if (b.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got valid=%b expected 0", b.out_valid);
        end
    endtask

    task automatic test_async_reset;
        b.out_ready = 1'b0;
        drive(1'b1, 32'h600, 32'h4000);
        tick();
        drive(1'b1, 32'h604, 32'h4001);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({b.out_valid, b.in_ready, count, stall_cnt, b.out_pc, b.out_instr} !==
            {1'b0, 1'b1, 2'd0, 16'd0, 32'h0, NOP}) begin
            fails++;
            $display("FAIL async_reset: got valid=%b ready=%b count=%0d stall=%0d pc=%h instr=%h",
                     b.out_valid, b.in_ready, count, stall_cnt, b.out_pc, b.out_instr);
        end
        tick();
        reset = 1'b0;
        b.out_ready = 1'b1;
        drive(1'b1, 32'h400, 32'h4002);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tests++;
        if ({b.out_valid, b.out_pc} !== {1'b1, 32'h400}) begin
            fails++;
            $display("FAIL post_reset_push: got valid=%b pc=%h expected valid=1 pc=400", b.out_valid, b.out_pc);
        end
        tick();
    endtask

    task automatic test_saturate;
        b2.in_valid = 1'b1;
        b2.in_pc    = 32'h500;
        b2.in_pc_4  = 32'h504;
        b2.in_instr = 32'h5000;
        b2.out_ready = 1'b0;
        tick();
        b2.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            tests++;
            if (stall_cnt2 !== ((k > 15) ? 4'd15 : 4'(k))) begin
                fails++;
                $display("FAIL sat_cycle%0d: got %0d expected %0d", k, stall_cnt2, (k > 15) ? 15 : k);
            end
        end
        tests++;
        if ({b2.out_valid, b2.out_pc} !== {1'b1, 32'h500}) begin
            fails++;
            $display("FAIL sat_hold: got valid=%b pc=%h expected valid=1 pc=500", b2.out_valid, b2.out_pc);
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        flush2 = 1'b0;
        b.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        b2.in_valid = 1'b0;
        b2.in_pc = '0;
        b2.in_pc_4 = '0;
        b2.in_instr = '0;
        b2.out_ready = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
